// File: rtl/image_sender_pkg.sv
// Shared types and constants for the image_sender frame streamer.
package image_sender_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSync0 = 3'd1,
    StSync1 = 3'd2,
    StFetch = 3'd3,
    StLoad  = 3'd4,
    StXmit  = 3'd5,
    StCksum = 3'd6,
    StDone  = 3'd7
  } sender_state_t;

  localparam logic [7:0] SYNC0_BYTE = 8'hA5;
  localparam logic [7:0] SYNC1_BYTE = 8'h5A;

endpackage

// File: rtl/image_sender_if.sv
// Request, frame-buffer read and UART byte-link signals of image_sender.
interface image_sender_if #(
  parameter int unsigned ADDR_W = 15
) ();

  logic              send;
  logic              done_send;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // The sender side.
  modport master (
    input  send, mem_data, tx_ready,
    output done_send, busy, mem_addr, mem_rd, tx_data, tx_valid
  );

  // The environment side: controller, frame buffer and UART.
  modport slave (
    output send, mem_data, tx_ready,
    input  done_send, busy, mem_addr, mem_rd, tx_data, tx_valid
  );

endinterface

// File: rtl/image_sender.sv
// Streams one frame from the frame buffer as A5 5A <pixels> <checksum> over a
// valid/ready byte link, then pulses done_send.
module image_sender
  import image_sender_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 19200,
  parameter int unsigned ADDR_W    = 15
) (
  input logic             clock,
  input logic             reset,
  image_sender_if.master  bus
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_BYTES - 1);

  sender_state_t     state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [7:0]        cksum_q, cksum_d;
  logic [7:0]        byte_q, byte_d;
  logic              xfer;

  assign xfer = bus.tx_valid && bus.tx_ready;

  // Next-state, pixel index, checksum and captured pixel byte.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cksum_d = cksum_q;
    byte_d  = byte_q;
    unique case (state_q)
      StIdle: begin
        if (bus.send) begin
          index_d = '0;
          cksum_d = '0;
          state_d = StSync0;
        end
      end
      StSync0: if (xfer) state_d = StSync1;
      StSync1: if (xfer) state_d = StFetch;
      StFetch: state_d = StLoad;
      StLoad: begin
        // Read data arrives one cycle after the strobe issued in StFetch.
        byte_d  = bus.mem_data;
        state_d = StXmit;
      end
      StXmit: begin
        if (xfer) begin
          cksum_d = cksum_q + byte_q;
          if (index_q == LastIdx) begin
            state_d = StCksum;
          end else begin
            index_d = index_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StCksum: if (xfer) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any partial frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      index_q <= '0;
      cksum_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cksum_q <= cksum_d;
      byte_q  <= byte_d;
    end
  end

  // Outputs decoded from state and registers only; tx_ready never reaches them.
  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.mem_rd    = (state_q == StFetch);
    bus.mem_addr  = index_q;
    bus.done_send = (state_q == StDone);
    bus.busy      = (state_q != StIdle);
    unique case (state_q)
      StSync0: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = SYNC0_BYTE;
      end
      StSync1: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = SYNC1_BYTE;
      end
      StXmit: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = byte_q;
      end
      StCksum: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = cksum_q;
      end
      default: ;
    endcase
  end

endmodule
